// File: rtl/bbframe_fill_scheduler_if.sv
// Byte-stream bundle between the TS FIFO, the fill scheduler and the BBHeader packer.
// master = scheduler side, slave = FIFO/packer environment side.
interface bbframe_fill_scheduler_if;
  logic       FIFO_EMPTY;
  logic [7:0] FIFO_DATA;
  logic [7:0] FIFO_INDEX;
  logic       FIFO_RD_REQ;
  logic       BB_READY;
  logic [7:0] BB_DATA;
  logic       BB_DVALID;
  logic       BB_LAST;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, FIFO_INDEX, BB_READY,
    output FIFO_RD_REQ, BB_DATA, BB_DVALID, BB_LAST
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, FIFO_INDEX, BB_READY,
    input  FIFO_RD_REQ, BB_DATA, BB_DVALID, BB_LAST
  );
endinterface

// File: rtl/bbframe_fill_scheduler.sv
// Fills one BBFrame data field per FRAME_START from the TS FIFO, zero-padding on stall,
// and reports DFL/SYNCD/UPL for header insertion.
module bbframe_fill_scheduler #(
  parameter int unsigned DF_BYTES       = 4826,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      DCLK_IN,
  input  logic                      RST,
  input  logic                      FRAME_START,
  input  logic                      NM_or_HEM,
  bbframe_fill_scheduler_if.master  bus,
  output logic                      FRAME_DONE,
  output logic [15:0]               DFL,
  output logic [15:0]               SYNCD,
  output logic [15:0]               UPL,
  output logic                      BUSY
);

  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [12:0] DF_CNT = 13'(DF_BYTES);
  localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT_CYCLES);

  generate
    if ((DF_BYTES * 8 > 65535) || (DF_BYTES == 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
      $error("bbframe_fill_scheduler: DF_BYTES*8 must fit 16 bits and TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_PAD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     count_q, count_d;
  logic [12:0]     real_q, real_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pend_q, pend_d;
  logic            hem_q, hem_d;
  logic            sync_found_q, sync_found_d;
  logic [15:0]     sync_off_q, sync_off_d;
  logic [15:0]     dfl_q, dfl_d;
  logic [15:0]     syncd_q, syncd_d;
  logic [15:0]     upl_q, upl_d;

  logic            rd_req;
  logic [7:0]      bb_data;
  logic            bb_dvalid;
  logic            bb_last;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    real_d       = real_q;
    tmo_d        = tmo_q;
    pend_d       = 1'b0;
    hem_d        = hem_q;
    sync_found_d = sync_found_q;
    sync_off_d   = sync_off_q;
    dfl_d        = dfl_q;
    syncd_d      = syncd_q;
    upl_d        = upl_q;
    rd_req       = 1'b0;
    bb_data      = '0;
    bb_dvalid    = 1'b0;
    bb_last      = 1'b0;

    // A read issued last cycle always lands now; count_q already includes it.
    if (pend_q) begin
      bb_dvalid = 1'b1;
      bb_data   = bus.FIFO_DATA;
      bb_last   = (count_q == DF_CNT);
      real_d    = real_q + 13'd1;
      if (!sync_found_q && (bus.FIFO_INDEX == 8'd1)) begin
        sync_found_d = 1'b1;
        sync_off_d   = {real_q, 3'b000};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (FRAME_START) begin
          state_d      = S_FILL;
          count_d      = '0;
          real_d       = '0;
          tmo_d        = '0;
          hem_d        = NM_or_HEM;
          sync_found_d = 1'b0;
          sync_off_d   = '0;
        end
      end
      S_FILL: begin
        rd_req = bus.BB_READY & ~bus.FIFO_EMPTY & (count_q < DF_CNT);
        if (rd_req) begin
          count_d = count_q + 13'd1;
          pend_d  = 1'b1;
          tmo_d   = '0;
        end else if (bus.FIFO_EMPTY && bus.BB_READY) begin
          tmo_d = tmo_q + 1'b1;
        end
        if (count_d == DF_CNT) begin
          state_d = S_DRAIN;
        end else if ((tmo_q == TO_CNT) && !rd_req) begin
          state_d = S_PAD;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_PAD: begin
        if (bus.BB_READY) begin
          bb_dvalid = 1'b1;
          bb_data   = 8'h00;
          count_d   = count_q + 13'd1;
          bb_last   = (count_d == DF_CNT);
          if (count_d == DF_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame report is registered on DONE entry so it changes with FRAME_DONE.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      dfl_d   = {real_d, 3'b000};
      syncd_d = sync_found_d ? sync_off_d : 16'hFFFF;
      upl_d   = hem_q ? 16'd1496 : 16'd1504;
    end
  end

  always_ff @(posedge DCLK_IN or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      real_q       <= '0;
      tmo_q        <= '0;
      pend_q       <= 1'b0;
      hem_q        <= 1'b0;
      sync_found_q <= 1'b0;
      sync_off_q   <= '0;
      dfl_q        <= '0;
      syncd_q      <= 16'hFFFF;
      upl_q        <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      real_q       <= real_d;
      tmo_q        <= tmo_d;
      pend_q       <= pend_d;
      hem_q        <= hem_d;
      sync_found_q <= sync_found_d;
      sync_off_q   <= sync_off_d;
      dfl_q        <= dfl_d;
      syncd_q      <= syncd_d;
      upl_q        <= upl_d;
    end
  end

  assign bus.FIFO_RD_REQ = rd_req;
  assign bus.BB_DATA     = bb_data;
  assign bus.BB_DVALID   = bb_dvalid;
  assign bus.BB_LAST     = bb_last;
  assign FRAME_DONE      = (state_q == S_DONE);
  assign BUSY            = (state_q != S_IDLE);
  assign DFL             = dfl_q;
  assign SYNCD           = syncd_q;
  assign UPL             = upl_q;

endmodule

// File: tb/tb_bbframe_fill_scheduler.sv
// Scoreboard bench for bbframe_fill_scheduler: FIFO model, expected byte queue per frame,
// frame report and reset checks.
module tb_bbframe_fill_scheduler;

  localparam int unsigned DF = 4826;
  localparam int unsigned TO = 64;
  localparam int unsigned MEMSZ = 32768;

  logic        DCLK_IN = 1'b0;
  logic        RST = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        NM_or_HEM = 1'b0;
  logic        FRAME_DONE;
  logic [15:0] DFL;
  logic [15:0] SYNCD;
  logic [15:0] UPL;
  logic        BUSY;

  bbframe_fill_scheduler_if bus ();

  bbframe_fill_scheduler #(
    .DF_BYTES       (DF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .DCLK_IN     (DCLK_IN),
    .RST         (RST),
    .FRAME_START (FRAME_START),
    .NM_or_HEM   (NM_or_HEM),
    .bus         (bus.master),
    .FRAME_DONE  (FRAME_DONE),
    .DFL         (DFL),
    .SYNCD       (SYNCD),
    .UPL         (UPL),
    .BUSY        (BUSY)
  );

  always #5 DCLK_IN = ~DCLK_IN;

  // Non-showahead FIFO model: q updates one cycle after a sampled read request.
  logic [7:0]  dat_mem [0:MEMSZ-1];
  logic [7:0]  idx_mem [0:MEMSZ-1];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign bus.FIFO_EMPTY = (rd_ptr == wr_ptr);

  always @(posedge DCLK_IN) begin
    if (bus.FIFO_RD_REQ && (rd_ptr != wr_ptr)) begin
      bus.FIFO_DATA  <= dat_mem[rd_ptr % MEMSZ];
      bus.FIFO_INDEX <= idx_mem[rd_ptr % MEMSZ];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  logic [8:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int m_n;
  int unsigned m_dfl;
  int unsigned m_syncd;
  int rd_cnt;
  int delivered;
  int gap_max;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_fifo(input int n, input int start_idx, input int lo_idx);
    int idx;
    idx = start_idx;
    for (int i = 0; i < n; i++) begin
      dat_mem[wr_ptr % MEMSZ] = 8'($urandom);
      idx_mem[wr_ptr % MEMSZ] = 8'(idx);
      wr_ptr = wr_ptr + 1;
      idx = (idx >= 187) ? lo_idx : idx + 1;
    end
  endtask

  // FIFO is never refilled during a frame, so its fill level now fixes the real/pad split.
  task automatic expect_frame();
    int unsigned avail;
    logic [7:0] d;
    avail   = wr_ptr - rd_ptr;
    m_n     = (avail < DF) ? int'(avail) : int'(DF);
    m_syncd = 32'hFFFF;
    m_dfl   = 32'(m_n) * 8;
    exp_q.delete();
    for (int i = 0; i < int'(DF); i++) begin
      if (i < m_n) begin
        d = dat_mem[(rd_ptr + i) % MEMSZ];
        if (idx_mem[(rd_ptr + i) % MEMSZ] == 8'd1 && m_syncd == 32'hFFFF) m_syncd = 32'(i) * 8;
      end else begin
        d = 8'h00;
      end
      exp_q.push_back({(i == int'(DF) - 1), d});
    end
  endtask

  task automatic run_frame(input bit hem, input bit toggle, input int abort_at);
    int  cyc;
    int  gap;
    bit  done;
    logic [8:0] e;
    expect_frame();
    rd_cnt = 0; delivered = 0; gap_max = 0; gap = 0; cyc = 0; done = 0;
    @(posedge DCLK_IN); #1;
    NM_or_HEM    = hem;
    FRAME_START  = 1'b1;
    bus.BB_READY = 1'b1;
    @(posedge DCLK_IN); #1;
    FRAME_START = 1'b0;
    while (!done && cyc < int'(DF) * 3 + 2000) begin
      @(negedge DCLK_IN);
      if (bus.FIFO_RD_REQ) begin
        chk("rdreq_while_ready", bus.BB_READY, 1'b1);
        chk("rdreq_not_empty", bus.FIFO_EMPTY, 1'b0);
        rd_cnt++;
      end
      if (bus.BB_DVALID) begin
        gap = 0;
        if (exp_q.size() == 0) begin
          chk("extra_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("bb_data", bus.BB_DATA, e[7:0]);
          chk("bb_last", bus.BB_LAST, e[8]);
        end
        delivered++;
      end else begin
        gap++;
        if (gap > gap_max) gap_max = gap;
      end
      if (FRAME_DONE) begin
        done = 1;
      end else if (abort_at != 0 && delivered == abort_at) begin
        return;
      end else begin
        @(posedge DCLK_IN); #1;
        FRAME_START  = (cyc == 100);
        bus.BB_READY = toggle ? ~bus.BB_READY : 1'b1;
        cyc++;
      end
    end
    if (!done) begin
      chk("frame_done_within_budget", 0, 1);
      return;
    end
    chk("dfl", DFL, m_dfl);
    chk("syncd", SYNCD, m_syncd);
    chk("upl", UPL, hem ? 32'd1496 : 32'd1504);
    chk("bytes_delivered", delivered, DF);
    chk("fifo_reads", rd_cnt, m_n);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("busy_in_done", BUSY, 1'b1);
    @(posedge DCLK_IN); #1;
    @(negedge DCLK_IN);
    chk("idle_after_done", BUSY, 1'b0);
    chk("frame_done_pulse", FRAME_DONE, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dvalid"}, bus.BB_DVALID, 1'b0);
    chk({tag, "_rdreq"}, bus.FIFO_RD_REQ, 1'b0);
    chk({tag, "_done"}, FRAME_DONE, 1'b0);
    chk({tag, "_dfl"}, DFL, 16'h0000);
    chk({tag, "_syncd"}, SYNCD, 16'hFFFF);
    chk({tag, "_upl"}, UPL, 16'h0000);
    chk({tag, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    bus.BB_READY = 1'b0;
    repeat (3) @(negedge DCLK_IN);
    chk_reset_vals("reset");
    RST = 1'b1;
    repeat (3) @(posedge DCLK_IN);

    // NM, aligned packets from index 0: index 1 sits at byte 1
    push_fifo(DF, 0, 0);
    run_frame(1'b0, 1'b0, 0);
    chk("nm_dfl_const", DFL, 16'(DF * 8));
    chk("nm_syncd_const", SYNCD, 16'd8);

    // HEM starting mid-packet at index 100
    push_fifo(DF, 100, 1);
    run_frame(1'b1, 1'b0, 0);
    chk("hem_syncd_const", SYNCD, 16'd704);
    chk("hem_upl_const", UPL, 16'd1496);

    // 1000 real bytes then stall -> pad
    push_fifo(1000, 0, 0);
    run_frame(1'b0, 1'b0, 0);
    chk("short_dfl_const", DFL, 16'd8000);
    chk("pad_after_timeout", (gap_max >= int'(TO)), 1'b1);

    // FIFO empty at FRAME_START
    run_frame(1'b0, 1'b0, 0);
    chk("empty_dfl_const", DFL, 16'd0);
    chk("empty_syncd_const", SYNCD, 16'hFFFF);

    // BB_READY toggling
    push_fifo(DF, 1, 1);
    run_frame(1'b1, 1'b1, 0);
    chk("toggle_syncd_const", SYNCD, 16'd0);

    // Reset in the middle of a frame, then restart from remaining FIFO content
    push_fifo(2000, 0, 0);
    run_frame(1'b0, 1'b0, 500);
    chk("abort_point", delivered, 500);
    @(posedge DCLK_IN); #1;
    RST = 1'b0;
    @(negedge DCLK_IN);
    chk_reset_vals("midreset");
    @(posedge DCLK_IN); #1;
    RST = 1'b1;
    repeat (3) @(posedge DCLK_IN);
    run_frame(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
